// File: rtl/oled_spi_rx.sv
// SPI slave standing in for a 96x64 SSD1331-style OLED: oversamples the 4-wire link and decodes
// address-window commands and pixel writes. Define COLOR16_EN for RGB565 pixels (two bytes each).
module oled_spi_rx #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        oled_csn,
    input  logic        oled_clk,
    input  logic        oled_mosi,
    input  logic        oled_dc,
    input  logic        oled_resn,
    output logic        pix_we,
    output logic [6:0]  pix_x,
    output logic [5:0]  pix_y,
`ifdef COLOR16_EN
    output logic [15:0] pix_color,
`else
    output logic [7:0]  pix_color,
`endif
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        display_on
);

`ifdef COLOR16_EN
    localparam int CW = 16;
`else
    localparam int CW = 8;
`endif
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [7:0] COL_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] ROW_MAX = 8'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, COL_S, COL_E, ROW_S, ROW_E} state_t;

    logic [NS-1:0] csn_sync, sck_sync, mosi_sync, dc_sync, resn_sync;
    logic          csn_s, sck_s, mosi_s, dc_s, resn_s, sck_prev, sck_rise;
    logic [2:0]    bit_cnt;
    logic [6:0]    shift;
    logic          byte_valid, byte_dc;
    logic [7:0]    byte_data;

    state_t        state;
    logic [6:0]    col_start, col_end, x, x_next, col_arg;
    logic [5:0]    row_start, row_end, y, y_next, row_arg;
    logic          col_wrap, row_wrap, pixel_fire;
    logic [CW-1:0] pixel_value;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csn_sync  <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            resn_sync <= '0;
        end else begin
            csn_sync  <= {csn_sync[NS-2:0], oled_csn};
            sck_sync  <= {sck_sync[NS-2:0], oled_clk};
            mosi_sync <= {mosi_sync[NS-2:0], oled_mosi};
            dc_sync   <= {dc_sync[NS-2:0], oled_dc};
            resn_sync <= {resn_sync[NS-2:0], oled_resn};
        end
    end

    assign csn_s    = csn_sync[NS-1];
    assign sck_s    = sck_sync[NS-1];
    assign mosi_s   = mosi_sync[NS-1];
    assign dc_s     = dc_sync[NS-1];
    assign resn_s   = resn_sync[NS-1];
    assign sck_rise = sck_s && !sck_prev && !csn_s;

    // Byte assembly; deselect or display reset drops any partial byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_prev   <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            sck_prev   <= sck_s;
            byte_valid <= 1'b0;
            if (!resn_s || csn_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_s};
                    byte_dc    <= dc_s;
                end
            end
        end
    end

`ifdef COLOR16_EN
    logic       pending;
    logic [7:0] color_hi;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending  <= 1'b0;
            color_hi <= '0;
        end else if (!resn_s || csn_s) begin
            pending <= 1'b0;
        end else if (byte_valid) begin
            if (!byte_dc || pending) begin
                pending <= 1'b0;
            end else begin
                pending  <= 1'b1;
                color_hi <= byte_data;
            end
        end
    end

    assign pixel_fire  = byte_valid && byte_dc && pending;
    assign pixel_value = {color_hi, byte_data};
`else
    assign pixel_fire  = byte_valid && byte_dc;
    assign pixel_value = byte_data;
`endif

    always_comb begin
        col_arg  = (byte_data > COL_MAX) ? COL_MAX[6:0] : byte_data[6:0];
        row_arg  = (byte_data > ROW_MAX) ? ROW_MAX[5:0] : byte_data[5:0];
        col_wrap = (x == col_end) || (col_start > col_end);
        row_wrap = (y == row_end) || (row_start > row_end);
        x_next   = col_wrap ? col_start : x + 7'd1;
        y_next   = y;
        if (col_wrap) begin
            y_next = row_wrap ? row_start : y + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            col_start <= '0;
            col_end <= COL_MAX[6:0];
            row_start <= '0;
            row_end <= ROW_MAX[5:0];
            x <= '0;
            y <= '0;
            pix_we <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            pix_color <= '0;
            cmd_valid <= 1'b0;
            cmd_byte <= '0;
            display_on <= 1'b0;
        end else if (!resn_s) begin
            state <= IDLE;
            col_start <= '0;
            col_end <= COL_MAX[6:0];
            row_start <= '0;
            row_end <= ROW_MAX[5:0];
            x <= '0;
            y <= '0;
            pix_we <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            pix_color <= '0;
            cmd_valid <= 1'b0;
            cmd_byte <= '0;
            display_on <= 1'b0;
        end else begin
            pix_we    <= 1'b0;
            cmd_valid <= 1'b0;
            if (byte_valid && byte_dc) begin
                // Data aborts any half-finished address command.
                state <= IDLE;
                if (pixel_fire) begin
                    pix_we    <= 1'b1;
                    pix_x     <= x;
                    pix_y     <= y;
                    pix_color <= pixel_value;
                    x         <= x_next;
                    y         <= y_next;
                end
            end else if (byte_valid) begin
                case (state)
                    IDLE: begin
                        if (byte_data == 8'h15) begin
                            state <= COL_S;
                        end else if (byte_data == 8'h75) begin
                            state <= ROW_S;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_byte  <= byte_data;
                            if (byte_data == 8'hAF) display_on <= 1'b1;
                            else if (byte_data == 8'hAE) display_on <= 1'b0;
                        end
                    end
                    COL_S: begin
                        col_start <= col_arg;
                        state     <= COL_E;
                    end
                    COL_E: begin
                        col_end <= col_arg;
                        x       <= col_start;
                        state   <= IDLE;
                    end
                    ROW_S: begin
                        row_start <= row_arg;
                        state     <= ROW_E;
                    end
                    ROW_E: begin
                        row_end <= row_arg;
                        y       <= row_start;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: pixel writes and command pulses are queued when sent and
// checked (values and latency) as the DUT emits them.
module tb_oled_spi_rx;

    localparam int SYNC = 2;
`ifdef COLOR16_EN
    localparam int CW = 16;
`else
    localparam int CW = 8;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          oled_csn = 1'b1;
    logic          oled_clk = 1'b0;
    logic          oled_mosi = 1'b0;
    logic          oled_dc = 1'b0;
    logic          oled_resn = 1'b1;
    logic          pix_we;
    logic [6:0]    pix_x;
    logic [5:0]    pix_y;
    logic [CW-1:0] pix_color;
    logic          cmd_valid;
    logic [7:0]    cmd_byte;
    logic          display_on;

    typedef struct packed {
        logic [6:0]    x;
        logic [5:0]    y;
        logic [CW-1:0] c;
    } pix_t;

    pix_t       pix_q[$];
    logic [7:0] cmd_q[$];
    pix_t       mon_p;
    logic [7:0] mon_c;
    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_rise = 0;

    oled_spi_rx #(.WIDTH(96), .HEIGHT(64), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetn(resetn), .oled_csn(oled_csn), .oled_clk(oled_clk),
        .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_resn(oled_resn),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .display_on(display_on)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Output monitor: every pulse must match the head of its queue and arrive SYNC+2 cycles after the 8th SCLK rise.
    initial forever begin
        @(negedge clk);
        if (resetn && pix_we) begin
            checks++;
            if (pix_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pix_we: got write at (%0d,%0d) color %h, no write expected", pix_x, pix_y, pix_color);
            end else begin
                mon_p = pix_q.pop_front();
                if (pix_x !== mon_p.x || pix_y !== mon_p.y || pix_color !== mon_p.c) begin
                    fails++;
                    $display("FAIL pix_write: got (%0d,%0d) color %h, expected (%0d,%0d) color %h",
                             pix_x, pix_y, pix_color, mon_p.x, mon_p.y, mon_p.c);
                end
            end
            checks++;
            if (cyc - last_rise != SYNC + 2) begin
                fails++;
                $display("FAIL pix_latency: got %0d cycles, expected %0d", cyc - last_rise, SYNC + 2);
            end
        end
        if (resetn && cmd_valid) begin
            checks++;
            if (cmd_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_cmd_valid: got cmd_byte %h, no command expected", cmd_byte);
            end else begin
                mon_c = cmd_q.pop_front();
                if (cmd_byte !== mon_c) begin
                    fails++;
                    $display("FAIL cmd_byte: got %h, expected %h", cmd_byte, mon_c);
                end
            end
            checks++;
            if (cyc - last_rise != SYNC + 2) begin
                fails++;
                $display("FAIL cmd_latency: got %0d cycles, expected %0d", cyc - last_rise, SYNC + 2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mode-0 shifting: data set while SCLK low, 3 fabric cycles per SCLK phase.
    task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits);
        oled_csn = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            oled_mosi = b[i];
            oled_dc   = dc;
            tick(3);
            oled_clk  = 1'b1;
            last_rise = cyc;
            tick(3);
            oled_clk  = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        spi_bits(b, dc, 8);
    endtask

    task automatic cmd_expect(input logic [7:0] b);
        cmd_q.push_back(b);
        send_byte(b, 1'b0);
    endtask

    task automatic send_pix(input logic [15:0] c, input int x, input int y);
        pix_t e;
        e.x = 7'(x);
        e.y = 6'(y);
        e.c = c[CW-1:0];
        pix_q.push_back(e);
`ifdef COLOR16_EN
        send_byte(c[15:8], 1'b1);
`endif
        send_byte(c[7:0], 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pix_q.size() != 0 || cmd_q.size() != 0) && n < 200) begin
            tick(1);
            n++;
        end
        tick(8);
        checks++;
        if (pix_q.size() != 0 || cmd_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d pixel and %0d command outputs missing, expected 0",
                     name, pix_q.size(), cmd_q.size());
            pix_q.delete();
            cmd_q.delete();
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({pix_we, pix_x, pix_y, pix_color, cmd_valid, cmd_byte, display_on} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got nonzero outputs x=%0d y=%0d color=%h cmd=%h on=%b, expected all 0",
                     pix_x, pix_y, pix_color, cmd_byte, display_on);
        end
        resetn = 1'b1;
        tick(SYNC + 4);
        cmd_expect(8'hAF);
        send_pix(16'hA55A, 0, 0);
        send_pix(16'hC33C, 1, 0);
        drain("pre_reset");
        spi_bits(8'hFF, 1'b1, 4);
        resetn = 1'b0;
        #1;
        checks++;
        if (display_on !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_display_on: got %b, expected 0", display_on);
        end
        checks++;
        if (cmd_byte !== 8'h00) begin
            fails++;
            $display("FAIL async_reset_cmd_byte: got %h, expected 00", cmd_byte);
        end
        checks++;
        if (pix_x !== 7'd0 || pix_y !== 6'd0) begin
            fails++;
            $display("FAIL async_reset_pix_xy: got (%0d,%0d), expected (0,0)", pix_x, pix_y);
        end
        checks++;
        if (pix_color !== '0 || pix_we !== 1'b0 || cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_pulses: got color %h we %b cv %b, expected 0 0 0", pix_color, pix_we, cmd_valid);
        end
        oled_csn = 1'b1;
        oled_clk = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(SYNC + 4);
        send_pix(16'h12A5, 0, 0);
        send_pix(16'h3411, 1, 0);
        drain("after_reset");
    endtask

    task automatic test_window();
        logic [7:0] cmds [6];
        int         ex [7];
        int         ey [7];
        cmds = '{8'h15, 8'h10, 8'h12, 8'h75, 8'h05, 8'h06};
        ex = '{16, 17, 18, 16, 17, 18, 16};
        ey = '{5, 5, 5, 6, 6, 6, 5};
        foreach (cmds[i]) send_byte(cmds[i], 1'b0);
        for (int i = 0; i < 7; i++) send_pix(16'(i * 16'h1357 + 16'h0021), ex[i], ey[i]);
        drain("window");
    endtask

    task automatic test_display();
        spi_bits(8'hFF, 1'b1, 5);
        oled_csn = 1'b1;
        tick(4);
        cmd_expect(8'hAF);
        drain("display_on");
        checks++;
        if (display_on !== 1'b1) begin
            fails++;
            $display("FAIL display_on_set: got %b, expected 1", display_on);
        end
        cmd_expect(8'hAE);
        drain("display_off");
        checks++;
        if (display_on !== 1'b0) begin
            fails++;
            $display("FAIL display_on_clear: got %b, expected 0", display_on);
        end
        // Data while a column command waits for its argument: parser drops back to IDLE.
        send_byte(8'h15, 1'b0);
        send_pix(16'hBEEF, 17, 5);
        cmd_expect(8'h42);
        drain("data_aborts_cmd");
    endtask

    task automatic test_resn();
        cmd_expect(8'hAF);
        send_byte(8'h15, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        drain("resn_setup");
        oled_resn = 1'b0;
        tick(SYNC + 3);
        oled_resn = 1'b1;
        tick(SYNC + 3);
        checks++;
        if (display_on !== 1'b0 || cmd_byte !== 8'h00) begin
            fails++;
            $display("FAIL resn_state: got display_on %b cmd_byte %h, expected 0 00", display_on, cmd_byte);
        end
        checks++;
        if (pix_x !== 7'd0 || pix_y !== 6'd0 || pix_color !== '0) begin
            fails++;
            $display("FAIL resn_outputs: got (%0d,%0d) color %h, expected (0,0) color 0", pix_x, pix_y, pix_color);
        end
        for (int i = 0; i < 20; i++) send_pix(16'(16'h0F01 * i), i, 0);
        drain("resn_window");
    endtask

    task automatic test_clamp();
        send_byte(8'h15, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'h00, 1'b0);
        send_pix(16'h7788, 95, 0);
        send_pix(16'h99AA, 95, 1);
        drain("clamp");
    endtask

    task automatic test_wrap();
        int ex;
        int ey;
        send_byte(8'h15, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h5F, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'h3E, 1'b0);
        send_byte(8'h3F, 1'b0);
        ex = 0;
        ey = 62;
        for (int i = 0; i < 193; i++) begin
            send_pix(16'($urandom), ex, ey);
            if (ex == 95) begin
                ex = 0;
                ey = (ey == 63) ? 62 : ey + 1;
            end else begin
                ex = ex + 1;
            end
        end
        drain("wrap");
    endtask

    initial begin
        test_reset();
        test_window();
        test_display();
        test_resn();
        test_clamp();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
